tf_seq_ctrl: RTL and testbench

- Sequencing controller directly upstream of TF_gen in the NTT datapath (modulus 65537).
- Replaces the hand-driven control stimulus with RTL that drives TF_gen's control inputs: TF_init_base, TF_init_const, TF_ren, TF_wen and it_depth_cnt.
- Runs base-load, const-load, start delay, then the per-stage read/update schedule, paced by a butterfly-ready stall input.
- Also drives the index used to select W_initial and Wc_initial words for the data inputs of TF_gen.

---
 rtl/tf_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_tf_seq_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tf_seq_ctrl.sv
`timescale 1ns/1ps
// Control sequencer feeding TF_gen: base load, const load, start delay, then the
// per-stage read/update schedule paced by the butterfly-ready stall input.
module tf_seq_ctrl #(
   parameter int D_WIDTH     = 32,
   parameter int K           = 3,
   parameter int NUM_STAGE   = 3,
   parameter int ITE0        = 512,
   parameter int ITE1        = 32,
   parameter int ITE2        = 2,
   parameter int BU_TOTAL    = 512,
   parameter int START_DELAY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               bu_ready,
   output logic               TF_init_base,
   output logic               TF_init_const,
   output logic               TF_ren,
   output logic               TF_wen,
   output logic [D_WIDTH-1:0] it_depth_cnt,
   output logic [D_WIDTH-1:0] base_idx,
   output logic               busy,
   output logic               done
);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT_BASE, S_INIT_CONST, S_DELAY, S_RUN_RD, S_RUN_WR, S_DONE
   } state_t;

   localparam logic [D_WIDTH-1:0] ONE        = D_WIDTH'(1);
   localparam logic [D_WIDTH-1:0] K_LAST     = D_WIDTH'(K - 1);
   localparam logic [D_WIDTH-1:0] DELAY_LAST = D_WIDTH'(START_DELAY - 1);
   localparam logic [D_WIDTH-1:0] STAGE_LAST = D_WIDTH'(NUM_STAGE - 1);
   localparam logic [D_WIDTH-1:0] BU_TOT     = D_WIDTH'(BU_TOTAL);

   // Last bu_cnt value of a group for the given stage.
   function automatic logic [D_WIDTH-1:0] grp_last(input logic [D_WIDTH-1:0] s);
      if (s == '0)
         return D_WIDTH'(ITE0 - 1);
      else if (s == ONE)
         return D_WIDTH'(ITE1 - 1);
      else
         return D_WIDTH'(ITE2 - 1);
   endfunction

   state_t             state_q, state_d;
   logic [D_WIDTH-1:0] depth_q, depth_d;
   logic [D_WIDTH-1:0] delay_q, delay_d;
   logic [D_WIDTH-1:0] stage_q, stage_d;
   logic [D_WIDTH-1:0] bu_cnt_q, bu_cnt_d;
   logic [D_WIDTH-1:0] sw_cnt_q, sw_cnt_d;
   logic               init_base_q, init_const_q, rd_q, wen_q, busy_q, done_q;
   logic [D_WIDTH-1:0] it_depth_q, base_idx_q;

   always_comb begin
      state_d  = state_q;
      depth_d  = depth_q;
      delay_d  = delay_q;
      stage_d  = stage_q;
      bu_cnt_d = bu_cnt_q;
      sw_cnt_d = sw_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_INIT_BASE;
               depth_d = '0;
            end
         end
         S_INIT_BASE: begin
            if (depth_q == K_LAST)
               state_d = S_INIT_CONST;
            else
               depth_d = depth_q + ONE;
         end
         S_INIT_CONST: begin
            delay_d  = '0;
            stage_d  = '0;
            bu_cnt_d = '0;
            sw_cnt_d = '0;
            state_d  = (START_DELAY == 0) ? S_RUN_RD : S_DELAY;
         end
         S_DELAY: begin
            if (delay_q == DELAY_LAST) begin
               state_d  = S_RUN_RD;
               stage_d  = '0;
               bu_cnt_d = '0;
               sw_cnt_d = '0;
            end else begin
               delay_d = delay_q + ONE;
            end
         end
         S_RUN_RD: begin
            if (bu_ready) begin
               sw_cnt_d = sw_cnt_q + ONE;
               if (bu_cnt_q == grp_last(stage_q))
                  state_d = S_RUN_WR;
               else
                  bu_cnt_d = bu_cnt_q + ONE;
            end
         end
         S_RUN_WR: begin
            bu_cnt_d = '0;
            state_d  = S_RUN_RD;
            if (sw_cnt_q == BU_TOT) begin
               sw_cnt_d = '0;
               if (stage_q == STAGE_LAST)
                  state_d = S_DONE;
               else
                  stage_d = stage_q + ONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         depth_q      <= '0;
         delay_q      <= '0;
         stage_q      <= '0;
         bu_cnt_q     <= '0;
         sw_cnt_q     <= '0;
         init_base_q  <= 1'b0;
         init_const_q <= 1'b0;
         rd_q         <= 1'b0;
         wen_q        <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         it_depth_q   <= '0;
         base_idx_q   <= '0;
      end else begin
         state_q      <= state_d;
         depth_q      <= depth_d;
         delay_q      <= delay_d;
         stage_q      <= stage_d;
         bu_cnt_q     <= bu_cnt_d;
         sw_cnt_q     <= sw_cnt_d;
         init_base_q  <= (state_d == S_INIT_BASE);
         init_const_q <= (state_d == S_INIT_CONST);
         rd_q         <= (state_d == S_RUN_RD);
         wen_q        <= (state_d == S_RUN_WR);
         busy_q       <= (state_d != S_IDLE);
         done_q       <= (state_d == S_DONE);
         if (state_d == S_INIT_BASE)
            it_depth_q <= depth_d;
         else if (state_d == S_RUN_RD || state_d == S_RUN_WR)
            it_depth_q <= stage_d;
         else
            it_depth_q <= '0;
         base_idx_q   <= (state_d == S_INIT_BASE) ? depth_d : '0;
      end
   end

   assign TF_init_base  = init_base_q;
   assign TF_init_const = init_const_q;
   assign TF_ren        = rd_q & bu_ready;
   assign TF_wen        = wen_q;
   assign it_depth_cnt  = it_depth_q;
   assign base_idx      = base_idx_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_tf_seq_ctrl.sv
`timescale 1ns/1ps
// Directed bench for tf_seq_ctrl: nominal run, stalls, async abort, start-while-busy.
module tb_tf_seq_ctrl;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          bu_ready = 1'b1;
   logic          TF_init_base, TF_init_const, TF_ren, TF_wen, busy, done;
   logic [DW-1:0] it_depth_cnt, base_idx;

   tf_seq_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .bu_ready      (bu_ready),
      .TF_init_base  (TF_init_base),
      .TF_init_const (TF_init_const),
      .TF_ren        (TF_ren),
      .TF_wen        (TF_wen),
      .it_depth_cnt  (it_depth_cnt),
      .base_idx      (base_idx),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc, ren_cnt, wen_cnt, done_cnt, done_cyc, viol, wen_bad, rd_since;
   int ren_stage [3];
   int wen_stage [3];
   int stall_a0 = -100, stall_a_len = 0, stall_b0 = -100, stall_b_len = 0;
   int xs0 = -1, xs1 = -1;
   logic prev_done = 1'b0;
   bit   run_active = 1'b0;

   function automatic int grp(input int s);
      if (s == 0) return 512;
      if (s == 1) return 32;
      return 2;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: drive this cycle's inputs after the edge, then sample outputs.
   task automatic tick();
      int d;
      @(posedge clk);
      #1;
      cyc++;
      start    = (cyc == xs0) || (cyc == xs1);
      bu_ready = !((cyc >= stall_a0 && cyc < stall_a0 + stall_a_len) ||
                   (cyc >= stall_b0 && cyc < stall_b0 + stall_b_len));
      #1;
      d = int'(it_depth_cnt);
      if (TF_ren && TF_wen) viol++;
      if (TF_init_base && TF_ren) viol++;
      if ((TF_init_base || TF_init_const) && (TF_ren || TF_wen)) viol++;
      if (done && prev_done) viol++;
      prev_done = done;
      if ((TF_init_base || TF_init_const || TF_ren || TF_wen || done) && !busy) viol++;
      if (run_active && !busy) viol++;
      if (!bu_ready && TF_ren) viol++;
      if (TF_ren) begin
         ren_cnt++;
         rd_since++;
         if (d < 3) ren_stage[d]++;
      end
      if (TF_wen) begin
         wen_cnt++;
         if (d < 3) begin
            wen_stage[d]++;
            if (rd_since != grp(d)) wen_bad++;
         end else begin
            wen_bad++;
         end
         rd_since = 0;
      end
      if (done) begin
         done_cnt++;
         done_cyc   = cyc;
         run_active = 1'b0;
      end
   endtask

   task automatic begin_run();
      cyc = 0; ren_cnt = 0; wen_cnt = 0; done_cnt = 0; done_cyc = 0;
      viol = 0; wen_bad = 0; rd_since = 0; prev_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ren_stage[i] = 0;
         wen_stage[i] = 0;
      end
      run_active = 1'b1;
      start = 1'b1;
      tick();
   endtask

   task automatic run_and_check(input string name, input int exp_done);
      begin_run();
      for (int k = 0; k < 3; k++) begin
         if (k > 0) tick();
         check({name, ".init_base"}, 32'(TF_init_base), 1);
         check({name, ".base_depth"}, it_depth_cnt, k);
         check({name, ".base_idx"}, base_idx, k);
      end
      tick();
      check({name, ".init_const"}, {30'd0, TF_init_const, TF_init_base}, 2);
      check({name, ".const_depth"}, it_depth_cnt, 0);
      for (int k = 5; k <= 6; k++) begin
         tick();
         check({name, ".delay_strobes"}, {27'd0, TF_init_base, TF_init_const, TF_ren, TF_wen, busy}, 1);
      end
      tick();
      check({name, ".first_ren"}, 32'(TF_ren), 1);
      check({name, ".first_ren_depth"}, it_depth_cnt, 0);
      while (done_cnt == 0 && cyc < 3000) tick();
      check({name, ".done_cycle"}, done_cyc, exp_done);
      tick();
      check({name, ".done_pulse_busy"}, {30'd0, done, busy}, 0);
      check({name, ".ren_total"}, ren_cnt, 1536);
      check({name, ".wen_total"}, wen_cnt, 273);
      check({name, ".wen_stage0"}, wen_stage[0], 1);
      check({name, ".wen_stage1"}, wen_stage[1], 16);
      check({name, ".wen_stage2"}, wen_stage[2], 256);
      check({name, ".ren_stage0"}, ren_stage[0], 512);
      check({name, ".ren_stage1"}, ren_stage[1], 512);
      check({name, ".ren_stage2"}, ren_stage[2], 512);
      check({name, ".wen_placement"}, wen_bad, 0);
      check({name, ".exclusivity"}, viol, 0);
      repeat (5) tick();
      check({name, ".idle_after"}, {30'd0, busy, done}, 0);
      check({name, ".done_count"}, done_cnt, 1);
      $display("[TB] run %s: done at cycle %0d, reads %0d, updates %0d", name, done_cyc, ren_cnt, wen_cnt);
   endtask

   initial begin
      #2 rst = 1'b0;
      #1;
      check("reset.strobes", {26'd0, TF_init_base, TF_init_const, TF_ren, TF_wen, busy, done}, 0);
      check("reset.depth", it_depth_cnt, 0);
      check("reset.base_idx", base_idx, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      repeat (3) tick();
      check("idle.busy", 32'(busy), 0);

      run_and_check("nominal", 1816);

      stall_a0 = 100;  stall_a_len = 5;
      stall_b0 = 1054; stall_b_len = 3;
      run_and_check("stall", 1824);
      stall_a0 = -100; stall_a_len = 0;
      stall_b0 = -100; stall_b_len = 0;

      // Abort between clock edges during stage 1.
      begin_run();
      while (cyc < 700) tick();
      check("abort.in_stage1", it_depth_cnt, 1);
      #2 rst = 1'b0;
      #1;
      run_active = 1'b0;
      check("abort.strobes", {26'd0, TF_init_base, TF_init_const, TF_ren, TF_wen, busy, done}, 0);
      check("abort.depth", it_depth_cnt, 0);
      repeat (2) tick();
      #2 rst = 1'b1;
      done_cnt = 0;
      repeat (20) tick();
      check("abort.no_done", done_cnt, 0);
      check("abort.idle", 32'(busy), 0);
      $display("[TB] run abort: reset at cycle 700, outputs cleared");
      run_and_check("restart", 1816);

      xs0 = 3; xs1 = 900;
      run_and_check("start_busy", 1816);
      xs0 = -1; xs1 = -1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
